capture_sequencer: RTL and testbench

//  Command-driven controller for the capture datapath. Decodes bytes from uart_rx and sequences
//  the test, sampler and sample-reader units through their activate/done handshakes.

---
 rtl/capture_sequencer.sv | 151 +++++++++++++++
 tb/tb_capture_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Command sequencer: decodes rx bytes, runs test/sampler/reader units, arbitrates sample-memory ownership.
// Latency: rx_ready sampled at edge N drives registered outputs from edge N; done seen at edge M clears activate at M.
// Backpressure: none; non-abort bytes arriving while busy are dropped, abort always wins.
module capture_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    parameter logic [7:0]  CMD_TEST       = 8'h11,
    parameter logic [7:0]  CMD_SAMPLE     = 8'h21,
    parameter logic [7:0]  CMD_READ       = 8'h22,
    parameter logic [7:0]  CMD_CAPTURE    = 8'h23,
    parameter logic [7:0]  CMD_ABORT      = 8'hFF
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    output logic       test_activate,
    input  logic       test_done,
    output logic       sampler_activate,
    input  logic       sampler_done,
    output logic       reader_activate,
    input  logic       reader_done,
    output logic       mem_owner,
    output logic       busy,
    output logic [1:0] err_code,
    output logic [7:0] state_code
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, RUN_TEST, RUN_SAMPLE, GAP, RUN_READ, ERROR
    } state_t;

    state_t           state;
    logic             cap_mode;
    logic [CNT_W-1:0] cnt;
    logic             unit_done;
    logic             abort_req;

    // A done only counts while its own activate is high, so stale levels are ignored.
    always_comb begin
        unit_done = 1'b0;
        case (state)
            RUN_TEST:   unit_done = test_done & test_activate;
            RUN_SAMPLE: unit_done = sampler_done & sampler_activate;
            RUN_READ:   unit_done = reader_done & reader_activate;
            default:    unit_done = 1'b0;
        endcase
    end

    assign abort_req = rx_ready && (rx_data == CMD_ABORT);

    always_ff @(posedge clk_50mhz) begin
        if (!reset) begin
            state            <= IDLE;
            cap_mode         <= 1'b0;
            cnt              <= '0;
            test_activate    <= 1'b0;
            sampler_activate <= 1'b0;
            reader_activate  <= 1'b0;
            mem_owner        <= 1'b0;
            busy             <= 1'b0;
            err_code         <= 2'b00;
            state_code       <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_ready) begin
                        cnt <= '0;
                        if (rx_data == CMD_TEST) begin
                            state         <= RUN_TEST;
                            test_activate <= 1'b1;
                            busy          <= 1'b1;
                            state_code    <= CMD_TEST;
                        end else if (rx_data == CMD_SAMPLE || rx_data == CMD_CAPTURE) begin
                            state            <= RUN_SAMPLE;
                            sampler_activate <= 1'b1;
                            busy             <= 1'b1;
                            cap_mode         <= (rx_data == CMD_CAPTURE);
                            state_code       <= rx_data;
                        end else if (rx_data == CMD_READ) begin
                            state      <= GAP;
                            mem_owner  <= 1'b1;
                            busy       <= 1'b1;
                            cap_mode   <= 1'b0;
                            state_code <= CMD_READ;
                        end else if (rx_data != CMD_ABORT) begin
                            state      <= ERROR;
                            err_code   <= 2'b01;
                            state_code <= 8'hEE;
                        end
                    end
                end
                RUN_TEST, RUN_SAMPLE, RUN_READ: begin
                    if (abort_req || (unit_done && !(state == RUN_SAMPLE && cap_mode))) begin
                        state            <= IDLE;
                        cap_mode         <= 1'b0;
                        test_activate    <= 1'b0;
                        sampler_activate <= 1'b0;
                        reader_activate  <= 1'b0;
                        mem_owner        <= 1'b0;
                        busy             <= 1'b0;
                        state_code       <= 8'h00;
                    end else if (unit_done) begin
                        // Capture: sampler finished, hand memory to the reader via one idle GAP cycle.
                        state            <= GAP;
                        sampler_activate <= 1'b0;
                        mem_owner        <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state            <= ERROR;
                        cap_mode         <= 1'b0;
                        test_activate    <= 1'b0;
                        sampler_activate <= 1'b0;
                        reader_activate  <= 1'b0;
                        mem_owner        <= 1'b0;
                        busy             <= 1'b0;
                        err_code         <= 2'b10;
                        state_code       <= 8'hEE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (abort_req) begin
                        state      <= IDLE;
                        cap_mode   <= 1'b0;
                        mem_owner  <= 1'b0;
                        busy       <= 1'b0;
                        state_code <= 8'h00;
                    end else begin
                        state           <= RUN_READ;
                        reader_activate <= 1'b1;
                        cnt             <= '0;
                    end
                end
                ERROR: begin
                    if (rx_ready) begin
                        state      <= IDLE;
                        err_code   <= 2'b00;
                        state_code <= 8'h00;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: expected output changes (with their cycle) are queued by stimulus
// and popped by a negedge monitor whenever the DUT output vector changes.
module tb_capture_sequencer;

    logic       clk_50mhz = 1'b0;
    logic       reset;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       test_activate, test_done;
    logic       sampler_activate, sampler_done;
    logic       reader_activate, reader_done;
    logic       mem_owner, busy;
    logic [1:0] err_code;
    logic [7:0] state_code;

    capture_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk_50mhz        (clk_50mhz),
        .reset            (reset),
        .rx_ready         (rx_ready),
        .rx_data          (rx_data),
        .test_activate    (test_activate),
        .test_done        (test_done),
        .sampler_activate (sampler_activate),
        .sampler_done     (sampler_done),
        .reader_activate  (reader_activate),
        .reader_done      (reader_done),
        .mem_owner        (mem_owner),
        .busy             (busy),
        .err_code         (err_code),
        .state_code       (state_code)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    typedef struct {
        int          cyc;
        logic [14:0] v;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [14:0] prev = '0;

    always @(posedge clk_50mhz) cyc++;

    function automatic logic [14:0] s(input logic ta, input logic sa, input logic ra, input logic mo,
                                      input logic bz, input logic [1:0] er, input logic [7:0] code);
        return {ta, sa, ra, mo, bz, er, code};
    endfunction

    function automatic logic [14:0] snap();
        return {test_activate, sampler_activate, reader_activate, mem_owner, busy, err_code, state_code};
    endfunction

    // Monitor: every change of the output vector must match the next queued expectation, cycle included.
    always @(negedge clk_50mhz) begin
        if (mon_en) begin
            logic [14:0] now;
            now = snap();
            if (now !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d got=%h expected no change", cyc, now);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.v !== now || e.cyc != cyc) begin
                        errors++;
                        $display("FAIL output_change got=%h@%0d expected=%h@%0d", now, cyc, e.v, e.cyc);
                    end
                end
                prev = now;
            end
        end
    end

    task automatic expect_at(input int dcyc, input logic [14:0] v);
        exp_t e;
        e.cyc = cyc + dcyc;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_50mhz);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data  = b;
        tick(1);
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    localparam logic [14:0] IDLE_V = 15'h0000;

    initial begin
        reset = 1'b0; rx_ready = 1'b0; rx_data = 8'h00;
        test_done = 1'b0; sampler_done = 1'b0; reader_done = 1'b0;
        tick(3);
        checks++;
        if (snap() !== IDLE_V) begin
            errors++;
            $display("FAIL reset_state got=%h expected=%h", snap(), IDLE_V);
        end
        reset = 1'b1;
        prev = snap();
        mon_en = 1'b1;
        tick(2);

        // Test unit run, done a few cycles after start.
        expect_at(1, s(1,0,0,0,1,2'b00,8'h11));
        send(8'h11);
        tick(3);
        expect_at(1, IDLE_V);
        test_done = 1'b1; tick(1); test_done = 1'b0;
        tick(2);

        // Capture: sample, one GAP cycle, then read.
        expect_at(1, s(0,1,0,0,1,2'b00,8'h23));
        send(8'h23);
        tick(3);
        expect_at(1, s(0,0,0,1,1,2'b00,8'h23));
        expect_at(2, s(0,0,1,1,1,2'b00,8'h23));
        sampler_done = 1'b1; tick(1); sampler_done = 1'b0;
        tick(3);
        expect_at(1, IDLE_V);
        reader_done = 1'b1; tick(1); reader_done = 1'b0;
        tick(2);

        // Sampler timeout after 8 active cycles, then any byte clears the error.
        expect_at(1, s(0,1,0,0,1,2'b00,8'h21));
        send(8'h21);
        expect_at(8, s(0,0,0,0,0,2'b10,8'hEE));
        tick(10);
        expect_at(1, IDLE_V);
        send(8'h00);
        tick(2);

        // Done arriving on the last allowed cycle beats the timeout.
        expect_at(1, s(0,1,0,0,1,2'b00,8'h21));
        send(8'h21);
        tick(7);
        expect_at(1, IDLE_V);
        sampler_done = 1'b1; tick(1); sampler_done = 1'b0;
        tick(2);

        // Abort coincident with sampler_done in capture: reader never starts.
        expect_at(1, s(0,1,0,0,1,2'b00,8'h23));
        send(8'h23);
        tick(2);
        expect_at(1, IDLE_V);
        sampler_done = 1'b1;
        send(8'hFF);
        sampler_done = 1'b0;
        tick(4);

        // Unknown command, then clear; stale test_done in IDLE does nothing.
        expect_at(1, s(0,0,0,0,0,2'b01,8'hEE));
        send(8'h42);
        tick(1);
        expect_at(1, IDLE_V);
        send(8'h5A);
        test_done = 1'b1; tick(2); test_done = 1'b0;
        tick(1);

        // Non-abort byte while sampling is dropped.
        expect_at(1, s(0,1,0,0,1,2'b00,8'h21));
        send(8'h21);
        tick(1);
        send(8'h22);
        tick(1);
        expect_at(1, IDLE_V);
        sampler_done = 1'b1; tick(1); sampler_done = 1'b0;
        tick(2);

        // Plain read: GAP then RUN_READ, code 22.
        expect_at(1, s(0,0,0,1,1,2'b00,8'h22));
        expect_at(2, s(0,0,1,1,1,2'b00,8'h22));
        send(8'h22);
        tick(2);
        expect_at(1, IDLE_V);
        reader_done = 1'b1; tick(1); reader_done = 1'b0;
        tick(2);

        // Reset mid RUN_READ, then a normal sample run.
        expect_at(1, s(0,0,0,1,1,2'b00,8'h22));
        expect_at(2, s(0,0,1,1,1,2'b00,8'h22));
        send(8'h22);
        tick(2);
        expect_at(1, IDLE_V);
        reset = 1'b0; rx_ready = 1'b1; rx_data = 8'h21;
        tick(1);
        reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
        tick(1);
        expect_at(1, s(0,1,0,0,1,2'b00,8'h21));
        send(8'h21);
        tick(2);
        expect_at(1, IDLE_V);
        sampler_done = 1'b1; tick(1); sampler_done = 1'b0;
        tick(4);

        mon_en = 1'b0;
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_change expected=%h@%0d got no change", e.v, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
